mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request, held until inst_ack
- inst_addr  in  32  fetch word address
- inst_ack  out  1  one-cycle fetch completion
- inst_rdata  out  32  fetched word, valid with inst_ack
- data_req  in  1  load/store request, held until data_ack
- data_write  in  1  1=store, 0=load
- data_sign_ext  in  1  sign-extend load result
- data_sel  in  4  access size: 0001 byte, 0011 half, 1111 word
- data_addr  in  32  byte address
- data_wdata  in  32  store data, right-aligned
- data_ack  out  1  one-cycle data completion
- data_err  out  1  valid with data_ack: misaligned or timeout
- data_rdata  out  32  aligned/extended load data, valid with data_ack
- inst_stall, data_stall  out  1  each  inst_req&~inst_ack, data_req&~data_ack (combinational)
- ram_en  out  1  RAM access active
- ram_we  out  4  byte write enables
- ram_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read word
- ram_ready  in  1  RAM completes access this cycle

Function
REQ-003 FSM states SHALL be IDLE, DATA, INST.
REQ-004 In IDLE with ack low, data_req SHALL win over inst_req. The winner's fields SHALL be latched and the FSM SHALL move to the matching state at the next edge.
REQ-005 A request SHALL NOT be accepted in the cycle its own ack is high.
REQ-006 In DATA/INST, ram_en SHALL be 1 and ram_addr/ram_we/ram_wdata SHALL be stable from the latched fields until ram_ready.
REQ-007 When ram_ready=1 in DATA/INST, the next edge SHALL assert the matching ack for exactly one cycle with registered rdata, and the FSM SHALL return to IDLE. Minimum latency is request sampled -> ack 2 cycles later.
REQ-008 Lane mapping:
- byte: ram_we = 0001 << addr[1:0]; wdata replicated x4
- half: ram_we = 0011 << {addr[1],1'b0}; wdata replicated x2
- word: ram_we = 1111
- loads: ram_we = 0000
REQ-009 Load data SHALL be extracted from the addressed lane and zero- or sign-extended to 32 bits per data_sign_ext.
REQ-010 A misaligned request SHALL make no RAM access; the next cycle SHALL assert data_ack with data_err=1 and data_rdata=0.
- misaligned = half with addr[0]=1, or word with addr[1:0]!=0
REQ-011 An unlisted data_sel value SHALL be treated as misaligned.
REQ-012 inst_ack and data_ack SHALL never be high in the same cycle.
REQ-013 When inst_req and data_req are both held, the inst request SHALL be served in the first IDLE cycle in which no data request is pending.

Reset
REQ-014 On rst the block SHALL go to IDLE and drive all outputs to 0: acks, err, rdata, ram_en, ram_we, ram_addr, ram_wdata.
REQ-015 A rst asserted mid-access SHALL abandon the access with no ack; requesters SHALL re-issue afterwards.

Configuration
REQ-016 With MEM_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in DATA/INST without ram_ready, and SHALL be cleared on state entry.
REQ-017 With MEM_ARB_TIMEOUT_EN defined, reaching count 255 SHALL abort the access and ack it next cycle with rdata=0. For a data access, data_err=1; an inst abort returns 0.
REQ-018 Without MEM_ARB_TIMEOUT_EN, no counter SHALL exist and accesses SHALL wait indefinitely.

Structure
REQ-019 Access-size encodings (byte/half/word sel), the state encoding and the timeout limit SHALL be defines in the shared bus/opcode headers.
REQ-020 Lane alignment and extension SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-021 Zero-wait RAM (ram_ready=1), byte load at addr 0x13 with ram_rdata=0x80AABBCC: data_ack 2 cycles after req; data_rdata=0xFFFFFF80 with sign_ext, 0x00000080 without.
REQ-022 Store half 0x1234 at addr 0x22: ram_we=1100, ram_wdata=0x12341234, ram_addr=0x20.
REQ-023 inst_req and data_req raised in the same cycle: data served first; inst_ack follows; acks are never simultaneous.
REQ-024 Word load at addr 0x05: no ram_en; data_ack with data_err=1 one cycle after acceptance.
REQ-025 ram_ready held low with MEM_ARB_TIMEOUT_EN defined: data_err ack after 255 wait cycles. Repeat with ram_ready arriving at cycle 3: normal ack.
REQ-026 rst asserted during DATA with ram_ready low: next cycle IDLE, ram_en=0, no ack; a new request after reset completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared encodings for the instruction/data memory bus arbiter
// Contents: access-size select encodings, arbiter state encoding, timeout limit
// and the alignment check used when a data request is accepted.
package mem_bus_arbiter_pkg;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Wait cycles without ram_ready before an access is abandoned.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } arb_state_e;

  // Any select value outside byte/half/word counts as misaligned.
  function automatic logic is_misaligned(input logic [3:0] sel, input logic [1:0] addr_lo);
    case (sel)
      SEL_BYTE: is_misaligned = 1'b0;
      SEL_HALF: is_misaligned = addr_lo[0];
      SEL_WORD: is_misaligned = |addr_lo;
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - combinational byte-lane steering for stores and load extraction
// Ports:
//   sel_i      in  4   access size select (byte/half/word)
//   addr_lo_i  in  2   byte offset within the word
//   write_i    in  1   1 = store, 0 = load
//   sign_ext_i in  1   sign-extend the extracted load value
//   wdata_i    in  32  right-aligned store data
//   rdata_i    in  32  raw RAM read word
//   we_o       out 4   byte write enables (zero for loads)
//   wdata_o    out 32  store data replicated across lanes
//   rdata_o    out 32  extracted and extended load data
module mem_lane_align
  import mem_bus_arbiter_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        write_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign lane_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    we_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (sel_i)
      SEL_BYTE: begin
        we_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & lane_byte[7]}}, lane_byte};
      end
      SEL_HALF: begin
        we_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & lane_half[15]}}, lane_half};
      end
      default: begin
        we_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
    if (!write_i) begin
      we_o = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - arbitrates instruction fetch and data load/store onto one RAM port
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abort accesses after 255 wait cycles).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch request held until inst_ack
//   inst_ack/inst_rdata           one-cycle fetch completion with fetched word
//   data_req/write/sign_ext/sel/addr/wdata  load/store request held until data_ack
//   data_ack/data_err/data_rdata  one-cycle data completion, error flag, load data
//   inst_stall, data_stall        request pending and not yet acked
//   ram_en/we/addr/wdata          RAM access driven from latched request fields
//   ram_rdata, ram_ready          RAM read word and completion strobe
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_write,
  input  logic        data_sign_ext,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic        inst_stall,
  output logic        data_stall,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        write_q, write_d;
  logic        sext_q, sext_d;
  logic        inst_ack_q, inst_ack_d;
  logic        data_ack_q, data_ack_d;
  logic        data_err_q, data_err_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        busy;
  logic        timeout;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign busy = (state_q != ST_IDLE);

  mem_lane_align u_lane_align (
    .sel_i      (sel_q),
    .addr_lo_i  (addr_q[1:0]),
    .write_i    (write_q),
    .sign_ext_i (sext_q),
    .wdata_i    (wdata_q),
    .rdata_i    (ram_rdata),
    .we_o       (lane_we),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_cnt_inc;

  // The counter is zero whenever the arbiter is idle, so each access starts from zero.
  assign wait_cnt_inc = wait_cnt_q + 8'd1;
  assign timeout      = busy && !ram_ready && (wait_cnt_inc == TIMEOUT_LIMIT);
  assign wait_cnt_d   = (busy && !ram_ready && !timeout) ? wait_cnt_inc : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    write_d      = write_q;
    sext_d       = sext_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    inst_rdata_d = 32'd0;
    data_rdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        // While an ack is showing, its requester still holds req; do not re-accept it.
        if (!inst_ack_q && !data_ack_q) begin
          if (data_req) begin
            if (is_misaligned(data_sel, data_addr[1:0])) begin
              data_ack_d = 1'b1;
              data_err_d = 1'b1;
            end else begin
              state_d = ST_DATA;
              addr_d  = data_addr;
              wdata_d = data_wdata;
              sel_d   = data_sel;
              write_d = data_write;
              sext_d  = data_sign_ext;
            end
          end else if (inst_req) begin
            state_d = ST_INST;
            addr_d  = inst_addr;
            wdata_d = 32'd0;
            sel_d   = SEL_WORD;
            write_d = 1'b0;
            sext_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (ram_ready) begin
          state_d      = ST_IDLE;
          data_ack_d   = 1'b1;
          data_rdata_d = write_q ? 32'd0 : lane_rdata;
        end else if (timeout) begin
          state_d    = ST_IDLE;
          data_ack_d = 1'b1;
          data_err_d = 1'b1;
        end
      end
      ST_INST: begin
        if (ram_ready) begin
          state_d      = ST_IDLE;
          inst_ack_d   = 1'b1;
          inst_rdata_d = ram_rdata;
        end else if (timeout) begin
          state_d    = ST_IDLE;
          inst_ack_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      sel_q        <= 4'd0;
      write_q      <= 1'b0;
      sext_q       <= 1'b0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      write_q      <= write_d;
      sext_q       <= sext_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_ack   = inst_ack_q;
  assign inst_rdata = inst_rdata_q;
  assign data_ack   = data_ack_q;
  assign data_err   = data_err_q;
  assign data_rdata = data_rdata_q;
  assign inst_stall = inst_req & ~inst_ack_q;
  assign data_stall = data_req & ~data_ack_q;

  // RAM side is quiet outside an access so misaligned requests never touch memory.
  assign ram_en    = busy;
  assign ram_we    = busy ? lane_we : 4'b0000;
  assign ram_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign ram_wdata = busy ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with a transaction-level model
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_write = 1'b0;
  logic        data_sign_ext = 1'b0;
  logic [3:0]  data_sel = 4'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_rdata;
  logic        inst_stall;
  logic        data_stall;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'd0;
  logic        ram_ready = 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: which request owns the RAM (0 none, 1 data, 2 inst) and its latched fields.
  int          m_busy = 0;
  int          m_wait = 0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wd   = 32'd0;
  logic [3:0]  m_sel  = 4'd0;
  bit          m_wr   = 1'b0;
  bit          m_sx   = 1'b0;
  // Expected registered outputs for the current cycle.
  bit          e_iack = 1'b0;
  bit          e_dack = 1'b0;
  bit          e_derr = 1'b0;
  bit          e_dchk = 1'b0;
  logic [31:0] e_irdata = 32'd0;
  logic [31:0] e_drdata = 32'd0;

  mem_bus_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_ack      (inst_ack),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_write    (data_write),
    .data_sign_ext (data_sign_ext),
    .data_sel      (data_sel),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_ack      (data_ack),
    .data_err      (data_err),
    .data_rdata    (data_rdata),
    .inst_stall    (inst_stall),
    .data_stall    (data_stall),
    .ram_en        (ram_en),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .ram_ready     (ram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_size(input logic [3:0] sel);
    if (sel == 4'b0001) return 1;
    if (sel == 4'b0011) return 2;
    if (sel == 4'b1111) return 4;
    return 0;
  endfunction

  function automatic bit m_misal(input logic [3:0] sel, input logic [31:0] addr);
    int sz;
    sz = m_size(sel);
    if (sz == 0) return 1'b1;
    return (int'(addr[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] m_we(input int sz, input int lo, input bit wr);
    int v;
    if (!wr) return 4'b0000;
    v = ((1 << sz) - 1) << lo;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wrep(input int sz, input logic [31:0] wd);
    if (sz == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int sz, input int lo, input bit sx);
    logic [31:0] mask;
    logic [31:0] v;
    logic [4:0]  msb;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rd >> (8 * lo)) & mask;
    msb  = 5'(8 * sz - 1);
    if (sx && v[msb]) v = v | ~mask;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present during the cycle that just ended.
  task automatic model_step();
    bit          n_iack, n_dack, n_derr, n_dchk;
    logic [31:0] n_ir, n_dr;
    n_iack = 0; n_dack = 0; n_derr = 0; n_dchk = 0; n_ir = 0; n_dr = 0;
    if (rst) begin
      m_busy = 0;
      m_wait = 0;
    end else if (m_busy != 0) begin
      if (ram_ready) begin
        if (m_busy == 1) begin
          n_dack = 1;
          n_dchk = !m_wr;
          n_dr   = m_wr ? 32'd0 : m_load(ram_rdata, m_size(m_sel), int'(m_addr[1:0]), m_sx);
        end else begin
          n_iack = 1;
          n_ir   = ram_rdata;
        end
        m_busy = 0;
      end else begin
        m_wait++;
        if (TO_EN && m_wait == 255) begin
          if (m_busy == 1) begin
            n_dack = 1; n_derr = 1; n_dchk = 1;
          end else begin
            n_iack = 1;
          end
          m_busy = 0;
        end
      end
    end else if (!e_iack && !e_dack) begin
      if (data_req) begin
        if (m_misal(data_sel, data_addr)) begin
          n_dack = 1; n_derr = 1; n_dchk = 1;
        end else begin
          m_busy = 1; m_wait = 0;
          m_addr = data_addr; m_wd = data_wdata; m_sel = data_sel;
          m_wr = data_write; m_sx = data_sign_ext;
        end
      end else if (inst_req) begin
        m_busy = 2; m_wait = 0;
        m_addr = inst_addr; m_wd = 32'd0; m_sel = 4'b1111; m_wr = 1'b0; m_sx = 1'b0;
      end
    end
    e_iack = n_iack; e_dack = n_dack; e_derr = n_derr; e_dchk = n_dchk;
    e_irdata = n_ir; e_drdata = n_dr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  // Compare DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inst_ack", {31'd0, inst_ack}, {31'd0, e_iack});
      chk("data_ack", {31'd0, data_ack}, {31'd0, e_dack});
      chk("ack_excl", {31'd0, inst_ack & data_ack}, 32'd0);
      if (e_dack) chk("data_err", {31'd0, data_err}, {31'd0, e_derr});
      if (e_dack && e_dchk) chk("data_rdata", data_rdata, e_drdata);
      if (e_iack) chk("inst_rdata", inst_rdata, e_irdata);
      chk("ram_en", {31'd0, ram_en}, {31'd0, m_busy != 0});
      if (m_busy != 0) begin
        chk("ram_addr", ram_addr, m_addr & ~32'd3);
        chk("ram_we", {28'd0, ram_we}, {28'd0, m_we(m_size(m_sel), int'(m_addr[1:0]), m_wr)});
        if (m_wr) chk("ram_wdata", ram_wdata, m_wrep(m_size(m_sel), m_wd));
      end else begin
        chk("ram_we_idle", {28'd0, ram_we}, 32'd0);
      end
      chk("inst_stall", {31'd0, inst_stall}, {31'd0, inst_req & ~e_iack});
      chk("data_stall", {31'd0, data_stall}, {31'd0, data_req & ~e_dack});
    end
  end

  task automatic set_data(input logic [3:0] sel, input logic [31:0] addr, input bit wr,
                          input bit sx, input logic [31:0] wd);
    data_req = 1'b1; data_sel = sel; data_addr = addr;
    data_write = wr; data_sign_ext = sx; data_wdata = wd;
  endtask

  task automatic wait_ack(input bit is_data, input int max, output int lat);
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!(is_data ? data_ack : inst_ack) && lat < max);
    if (!(is_data ? data_ack : inst_ack)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ack: no ack within %0d cycles (data=%0d)", max, is_data);
    end
  endtask

  // Hold req through the ack cycle, then release it and confirm it was not taken again.
  task automatic finish_data();
    cycle();
    data_req = 1'b0;
    chk("no_reaccept", {31'd0, ram_en}, 32'd0);
  endtask

  initial begin
    int lat;
    bit d_done, i_done;
    int r;

    cycle();
    chk_en = 1'b1;
    cycle();
    chk("rst_inst_ack", {31'd0, inst_ack}, 32'd0);
    chk("rst_data_ack", {31'd0, data_ack}, 32'd0);
    chk("rst_data_err", {31'd0, data_err}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    ram_ready = 1'b1;
    cycle();

    // Byte load at 0x13, signed then unsigned.
    ram_rdata = 32'h80AA_BBCC;
    set_data(4'b0001, 32'h13, 1'b0, 1'b1, 32'd0);
    wait_ack(1'b1, 10, lat);
    chk("lb_sext_lat", lat, 32'd2);
    chk("lb_sext_rdata", data_rdata, 32'hFFFF_FF80);
    finish_data();
    set_data(4'b0001, 32'h13, 1'b0, 1'b0, 32'd0);
    wait_ack(1'b1, 10, lat);
    chk("lb_zext_rdata", data_rdata, 32'h0000_0080);
    finish_data();

    // Signed half load from upper lane.
    set_data(4'b0011, 32'h12, 1'b0, 1'b1, 32'd0);
    wait_ack(1'b1, 10, lat);
    chk("lh_sext_rdata", data_rdata, 32'hFFFF_80AA);
    finish_data();

    // Half store 0x1234 at 0x22.
    set_data(4'b0011, 32'h22, 1'b1, 1'b0, 32'h0000_1234);
    cycle();
    chk("sh_ram_we", {28'd0, ram_we}, 32'h0000_000C);
    chk("sh_ram_wdata", ram_wdata, 32'h1234_1234);
    chk("sh_ram_addr", ram_addr, 32'h0000_0020);
    wait_ack(1'b1, 10, lat);
    finish_data();

    // Simultaneous requests: data first, then inst.
    ram_rdata = 32'hDEAD_BEEF;
    inst_req = 1'b1; inst_addr = 32'h100;
    set_data(4'b1111, 32'h40, 1'b0, 1'b0, 32'd0);
    cycle();
    chk("both_ram_addr", ram_addr, 32'h0000_0040);
    wait_ack(1'b1, 10, lat);
    chk("both_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("both_no_iack", {31'd0, inst_ack}, 32'd0);
    cycle();
    data_req = 1'b0;
    wait_ack(1'b0, 10, lat);
    chk("both_inst_lat", lat, 32'd2);
    chk("both_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    cycle();
    inst_req = 1'b0;

    // Misaligned word load and unlisted select.
    set_data(4'b1111, 32'h05, 1'b0, 1'b0, 32'd0);
    cycle();
    chk("mis_ack", {31'd0, data_ack}, 32'd1);
    chk("mis_err", {31'd0, data_err}, 32'd1);
    chk("mis_rdata", data_rdata, 32'd0);
    chk("mis_ram_en", {31'd0, ram_en}, 32'd0);
    finish_data();
    set_data(4'b0101, 32'h00, 1'b0, 1'b0, 32'd0);
    wait_ack(1'b1, 10, lat);
    chk("badsel_lat", lat, 32'd1);
    chk("badsel_err", {31'd0, data_err}, 32'd1);
    finish_data();

    // RAM ready arriving during the third cycle in the access.
    ram_ready = 1'b0;
    set_data(4'b1111, 32'h80, 1'b0, 1'b0, 32'd0);
    lat = 0;
    while (!data_ack && lat < 20) begin
      cycle();
      lat++;
      if (lat == 3) ram_ready = 1'b1;
    end
    chk("ready3_lat", lat, 32'd4);
    chk("ready3_err", {31'd0, data_err}, 32'd0);
    finish_data();

`ifdef MEM_ARB_TIMEOUT_EN
    ram_ready = 1'b0;
    set_data(4'b1111, 32'h84, 1'b0, 1'b0, 32'd0);
    wait_ack(1'b1, 400, lat);
    chk("timeout_lat", lat, 32'd256);
    chk("timeout_err", {31'd0, data_err}, 32'd1);
    chk("timeout_rdata", data_rdata, 32'd0);
    finish_data();
    ram_ready = 1'b1;
`endif

    // Reset in the middle of a stalled access.
    ram_ready = 1'b0;
    set_data(4'b1111, 32'h44, 1'b0, 1'b0, 32'd0);
    cycle();
    chk("midrst_en_before", {31'd0, ram_en}, 32'd1);
    rst = 1'b1;
    cycle();
    chk("midrst_en_after", {31'd0, ram_en}, 32'd0);
    chk("midrst_no_ack", {31'd0, data_ack}, 32'd0);
    rst = 1'b0;
    ram_ready = 1'b1;
    wait_ack(1'b1, 10, lat);
    chk("midrst_reissue_lat", lat, 32'd2);
    chk("midrst_reissue_err", {31'd0, data_err}, 32'd0);
    finish_data();

    // Randomized traffic from two agents and a variable-latency RAM.
    d_done = 0;
    i_done = 0;
    for (int c = 0; c < 4000; c++) begin
      cycle();
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (d_done) data_req = 1'b0;
      if (i_done) inst_req = 1'b0;
      if (!data_req && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        set_data((r < 3) ? 4'b0001 : (r < 6) ? 4'b0011 : (r < 9) ? 4'b1111 : 4'($urandom_range(0, 15)),
                 $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
      end
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req  = 1'b1;
        inst_addr = $urandom();
      end
      d_done    = e_dack;
      i_done    = e_iack;
      ram_ready = ($urandom_range(0, 9) < 6);
      ram_rdata = $urandom();
    end

    rst = 1'b0;
    data_req = 1'b0;
    inst_req = 1'b0;
    ram_ready = 1'b1;
    repeat (5) cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
